// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
//
// Decodes a 3-bit line index into an 8-bit one-hot word and buffers the
// decoded words in a small FIFO between two valid/ready interfaces. A sticky
// register accumulates the OR of every decoded word that has been accepted.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that edge;
// ready may change freely, and valid never waits on ready.
//
// Parameters
//   DEPTH      FIFO depth in entries (2, 4 or 8)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream code is valid
//   in_ready   block can accept a code (depends on registered occupancy only)
//   in_code    binary line index 0..7
//   in_none    no active line upstream; the decoded word is 8'h00
//   out_valid  out_onehot holds a decoded word (FIFO not empty)
//   out_ready  downstream accepts the head word
//   out_onehot decoded word at the FIFO head, 8'h00 while empty
//   seen       sticky OR of all accepted decoded words
//   clr        synchronous clear of seen
//   count      current FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module onehot_decoder #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_code,
    input  logic                     in_none,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_onehot,
    output logic [7:0]               seen,
    input  logic                     clr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage is deliberately not reset; out_onehot is masked while empty.
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       seen_q;

    logic             wr_en;
    logic             rd_en;
    logic [7:0]       dec_word;

    // Decode: one bit per line index, or all-zero when upstream found nothing.
    always_comb begin
        dec_word = 8'h00;
        if (!in_none) begin
            dec_word[in_code] = 1'b1;
        end
    end

    // Status flags come straight from the occupancy register, so in_ready has
    // no combinational path from out_ready. A full FIFO refuses a write even
    // when a pop happens in the same cycle; the word is taken next cycle.
    always_comb begin
        in_ready   = (cnt_q < FULL_CNT);
        out_valid  = (cnt_q != '0);
        wr_en      = in_valid && in_ready;
        rd_en      = out_valid && out_ready;
        out_onehot = out_valid ? mem[rd_ptr] : 8'h00;
        count      = cnt_q;
        seen       = seen_q;
    end

    // Data array: written only on an accept, so in_code/in_none are sampled
    // only then.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= dec_word;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous write and read leave it unchanged. With one
    // entry, the read moves rd_ptr onto the slot being written, so the new
    // word becomes the head on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky seen register. An accept that coincides with clr restarts the
    // history from that word rather than losing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 8'h00;
        end else if (wr_en) begin
            seen_q <= clr ? dec_word : (seen_q | dec_word);
        end else if (clr) begin
            seen_q <= 8'h00;
        end
    end

endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the FIFO depth in entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream code is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a code.
REQ-006 The block SHALL have port in_code, input, 3 bits: the binary line index, 0..7.
REQ-007 The block SHALL have port in_none, input, 1 bit: upstream found no active line, so in_code is ignored.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_onehot holds a valid decoded word.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-010 The block SHALL have port out_onehot, output, 8 bits: the decoded word at the FIFO head.
REQ-011 The block SHALL have port seen, output, 8 bits: the sticky OR of all accepted decoded words.
REQ-012 The block SHALL have port clr, input, 1 bit: a synchronous clear of seen.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-014 The decode SHALL be: in_none=0 gives bit in_code set, all other bits 0; in_none=1 gives 8'h00 regardless of in_code.
REQ-015 A write (accept) SHALL occur on a cycle with in_valid=1 and in_ready=1; the decoded word is pushed at the FIFO tail.
REQ-016 A read (pop) SHALL occur on a cycle with out_valid=1 and out_ready=1; the head entry is removed.
REQ-017 in_ready SHALL equal (count < DEPTH), registered-state based only, with no combinational dependence on out_ready.
REQ-018 out_valid SHALL equal (count != 0); out_onehot SHALL equal the head entry and SHALL be 8'h00 when count=0.
REQ-019 Latency SHALL be 1 cycle: a word accepted at edge N is visible with out_valid=1 after edge N; there is no same-cycle bypass.
REQ-020 Occupancy rules: write only gives count+1; read only gives count-1; write and read in the same cycle leave count unchanged and replace the head correctly, including when count=1.
REQ-021 When full (count=DEPTH), in_ready=0; an in_valid word is held upstream, never dropped or overwritten, even if out_ready=1 in that cycle; it is accepted in the next cycle.
REQ-022 When empty, out_ready has no effect and count never underflows.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; ordering is strict FIFO across the wrap.
REQ-024 seen SHALL update on each accepted word to seen | decoded; an in_none word leaves seen unchanged.
REQ-025 When clr=1 and no accept occurs in the same cycle, seen SHALL become 8'h00.
REQ-026 When clr=1 coincides with an accept, seen SHALL become exactly the decoded word of that accept.
REQ-027 Handshake stability: once out_valid=1, out_onehot SHALL stay stable until popped.
REQ-028 in_code and in_none SHALL be sampled only on an accept.

Reset
REQ-029 While rst=1, the block SHALL immediately hold count=0, pointers=0, out_valid=0, out_onehot=8'h00, seen=8'h00, and in_ready=1.
REQ-030 Deassertion of rst SHALL take effect at the next clk edge; reset mid-transfer discards all FIFO contents without emitting partial words.
REQ-031 FIFO storage contents need not be reset, but out_onehot SHALL still read 8'h00 while empty.

Verification
REQ-032 Single transfer: code 5 accepted with out_ready=1 -> next cycle out_valid=1, out_onehot=8'h20, seen=8'h20; popped the following cycle.
REQ-033 in_none: in_none=1 with in_code=3 -> out_onehot=8'h00, seen unchanged.
REQ-034 Backpressure with DEPTH=2 and out_ready=0: push codes 1, 7, 2 -> first two accepted, in_ready=0, code 2 held; raising out_ready yields 8'h02, 8'h80, 8'h04 in order, with count never exceeding 2.
REQ-035 Full streaming: in_valid=1 and out_ready=1 for codes 0..7 repeated 3 times -> one word per cycle after a 1-cycle fill, order preserved across pointer wrap, final seen=8'hFF.
REQ-036 clr collision: seen=8'h81, then clr=1 with accept of code 4 -> seen=8'h10; next cycle clr=1 with no accept -> seen=8'h00.
REQ-037 Reset mid-operation: count=2, assert rst asynchronously between edges -> out_valid=0, count=0, seen=8'h00 without waiting for an edge; after release, the first word out is the first word accepted after reset.
